cache_ctrl: RTL and testbench

Sequencing controller for the 4-way set-associative cache and its LRU age block. It accepts one CPU read/write at a time and runs tag lookup, dirty-victim write-back, line fill and write-allocate. It drives the per-way write enables and hit pulses that update both the cache arrays and the LRU ages. It sits between the CPU port, the way arrays/tag comparators, the LRU age block and the external memory port.

---
 rtl/cache_ctrl.sv | 118 +++++++++++
 tb/tb_cache_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 4-way set-associative cache (lookup, write-back, fill, write-allocate)
module cache_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_cpu_busy,
  output logic              o_cpu_done,
  output logic [ADDR_W-1:0] o_lat_addr,
  output logic [DATA_W-1:0] o_lat_wdata,
  input  logic [3:0]        i_hit,
  input  logic [3:0]        i_dirty,
  input  logic [3:0]        i_lru_bit,
  input  logic [ADDR_W-1:0] i_wb_addr,
  output logic [3:0]        o_wren_cache,
  output logic [3:0]        o_hit_pulse,
  output logic              o_wr_dirty,
  output logic              o_data_sel,
  output logic [DATA_W-1:0] o_fill_data,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wdata_en,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [15:0]       o_hit_cnt,
  output logic [15:0]       o_miss_cnt
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, ALLOC, DONE} state_t;
  state_t r_state, w_next;
  logic              r_we, r_realloc, r_wr_dirty;
  logic [3:0]        r_victim, r_wren, r_hit_pulse, w_victim;
  logic [ADDR_W-1:0] r_vaddr, r_lat_addr;
  logic [DATA_W-1:0] r_lat_wdata, r_fill;
  logic [15:0]       r_hit_cnt, r_miss_cnt;
  logic              w_hit;
  assign w_hit = |i_hit;
  assign w_victim = (i_lru_bit == 4'd0) ? 4'b0001 : (i_lru_bit & (~i_lru_bit + 4'd1));
  always_ff @(posedge i_clk)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_cpu_req ? LOOKUP : IDLE;
      LOOKUP:  w_next = w_hit ? DONE : (|(i_dirty & w_victim)) ? WB : FILL;
      WB:      w_next = i_mem_ack ? FILL : WB;
      FILL:    w_next = i_mem_ack ? ALLOC : FILL;
      ALLOC:   w_next = r_we ? LOOKUP : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we        <= 1'b0;
      r_realloc   <= 1'b0;
      r_wr_dirty  <= 1'b0;
      r_victim    <= '0;
      r_wren      <= '0;
      r_hit_pulse <= '0;
      r_vaddr     <= '0;
      r_lat_addr  <= '0;
      r_lat_wdata <= '0;
      r_fill      <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_wren      <= '0;
      r_hit_pulse <= '0;
      r_wr_dirty  <= 1'b0;
      case (r_state)
        IDLE: if (i_cpu_req) begin
          r_we        <= i_cpu_we;
          r_lat_addr  <= i_cpu_addr;
          r_lat_wdata <= i_cpu_wdata;
          r_realloc   <= 1'b0;
        end
        LOOKUP: if (w_hit) begin
          r_wren      <= r_we ? i_hit : 4'd0;
          r_wr_dirty  <= r_we;
          r_hit_pulse <= r_we ? 4'd0 : i_hit;
          if (!r_realloc) r_hit_cnt <= r_hit_cnt + {15'd0, r_hit_cnt != 16'hFFFF};
        end else begin
          r_victim   <= w_victim;
          r_vaddr    <= i_wb_addr;
          r_miss_cnt <= r_miss_cnt + {15'd0, r_miss_cnt != 16'hFFFF};
        end
        FILL: if (i_mem_ack) begin
          r_fill <= i_mem_rdata;
          r_wren <= r_victim;
        end
        ALLOC: r_realloc <= r_we;
        default: ;
      endcase
    end
  end
  assign o_cpu_busy     = r_state != IDLE;
  assign o_cpu_done     = r_state == DONE;
  assign o_lat_addr     = r_lat_addr;
  assign o_lat_wdata    = r_lat_wdata;
  assign o_wren_cache   = r_wren;
  assign o_hit_pulse    = r_hit_pulse;
  assign o_wr_dirty     = r_wr_dirty;
  assign o_data_sel     = r_state == ALLOC;
  assign o_fill_data    = r_fill;
  assign o_mem_req      = (r_state == WB) || (r_state == FILL);
  assign o_mem_we       = r_state == WB;
  assign o_mem_wdata_en = r_state == WB;
  assign o_mem_addr     = (r_state == WB) ? r_vaddr : (r_state == FILL) ? r_lat_addr : '0;
  assign o_hit_cnt      = r_hit_cnt;
  assign o_miss_cnt     = r_miss_cnt;
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed and randomized transactions checked against a transaction-level reference model
module tb_cache_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req, cpu_we, mem_ack;
  logic [7:0] cpu_addr, cpu_wdata, wb_addr, mem_rdata;
  logic [3:0] hit, dirty, lru;
  logic cpu_busy, cpu_done, wr_dirty, data_sel, mem_req, mem_we, mem_wdata_en;
  logic [7:0] lat_addr, lat_wdata, fill_data, mem_addr;
  logic [3:0] wren, hit_pulse;
  logic [15:0] hit_cnt, miss_cnt;
  int checks = 0, failures = 0, m_hit = 0, m_miss = 0, k;
  logic bad;
  logic [3:0] h;
  always #5 clk = ~clk;
  cache_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_busy(cpu_busy), .o_cpu_done(cpu_done), .o_lat_addr(lat_addr),
    .o_lat_wdata(lat_wdata), .i_hit(hit), .i_dirty(dirty), .i_lru_bit(lru), .i_wb_addr(wb_addr),
    .o_wren_cache(wren), .o_hit_pulse(hit_pulse), .o_wr_dirty(wr_dirty), .o_data_sel(data_sel),
    .o_fill_data(fill_data), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata_en(mem_wdata_en), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
    .o_hit_cnt(hit_cnt), .o_miss_cnt(miss_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [3:0] h_in, input logic [3:0] d_in, input logic [3:0] l_in,
                         input logic [7:0] wba, input int lwb, input int lfill, input logic [7:0] rdata);
    logic miss, dmiss, busy_ok, prev_req, prev_we;
    logic [7:0] prev_a;
    logic [3:0] vic, hp_v;
    int exp_lat, done_cyc, done_n, hp_n, ph_start, lat;
    logic [3:0] w_en[$], e_en[$];
    logic w_d[$], w_s[$], e_d[$], e_s[$];
    logic [7:0] w_f[$];
    logic m_we[$], m_en[$], x_we[$], x_en[$];
    logic [7:0] m_a[$], x_a[$];
    miss = h_in == 4'd0;
    vic = 4'b0001;
    for (int i = 3; i >= 0; i--) if (l_in[i]) vic = 4'(1 << i);
    dmiss = miss && ((d_in & vic) != 4'd0);
    exp_lat = !miss ? 2 : dmiss ? 5 + lwb + lfill : 4 + lfill;
    if (miss && we) exp_lat++;
    if (miss) m_miss = (m_miss < 65535) ? m_miss + 1 : m_miss;
    else m_hit = (m_hit < 65535) ? m_hit + 1 : m_hit;
    if (!miss && we) begin e_en.push_back(h_in); e_d.push_back(1'b1); e_s.push_back(1'b0); end
    if (miss) begin e_en.push_back(vic); e_d.push_back(1'b0); e_s.push_back(1'b1); end
    if (miss && we) begin e_en.push_back(vic); e_d.push_back(1'b1); e_s.push_back(1'b0); end
    if (dmiss) begin x_we.push_back(1'b1); x_a.push_back(wba); x_en.push_back(1'b1); end
    if (miss) begin x_we.push_back(1'b0); x_a.push_back(addr); x_en.push_back(1'b0); end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    hit = h_in; dirty = d_in; lru = l_in; wb_addr = wba; mem_ack = 1'b0; mem_rdata = ~rdata;
    done_cyc = -1; done_n = 0; hp_n = 0; hp_v = 4'd0; busy_ok = 1'b1;
    prev_req = 1'b0; prev_we = 1'b0; prev_a = 8'd0; ph_start = 0;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (cpu_done) begin done_n++; if (done_cyc < 0) done_cyc = c; end
      if (cpu_busy !== ((done_cyc < 0) || (c == done_cyc))) busy_ok = 1'b0;
      if (hit_pulse != 4'd0) begin hp_n++; hp_v = hit_pulse; end
      if (wren != 4'd0) begin
        w_en.push_back(wren); w_d.push_back(wr_dirty); w_s.push_back(data_sel); w_f.push_back(fill_data);
      end
      if (data_sel) hit = wren;
      if (mem_req) begin
        if (!prev_req || mem_we !== prev_we || mem_addr !== prev_a) begin
          ph_start = c; m_we.push_back(mem_we); m_a.push_back(mem_addr); m_en.push_back(mem_wdata_en);
        end
        lat = mem_we ? lwb : lfill;
        mem_ack = (c - ph_start) == lat;
      end else mem_ack = 1'b0;
      mem_rdata = mem_ack ? rdata : ~rdata;
      prev_req = mem_req; prev_we = mem_we; prev_a = mem_addr;
      if (c == done_cyc) cpu_req = 1'b0;
      if (done_cyc > 0 && c >= done_cyc + 2) break;
    end
    cpu_req = 1'b0; mem_ack = 1'b0;
    chk("done_cycle", 32'(done_cyc), 32'(exp_lat));
    chk("done_count", 32'(done_n), 32'd1);
    chk("busy", 32'(busy_ok), 32'd1);
    chk("hit_pulse_n", 32'(hp_n), (!miss && !we) ? 32'd1 : 32'd0);
    chk("hit_pulse_v", 32'(hp_v), (!miss && !we) ? 32'(h_in) : 32'd0);
    chk("wren_n", 32'(w_en.size()), 32'(e_en.size()));
    for (int i = 0; i < e_en.size() && i < w_en.size(); i++) begin
      chk("wren_way", 32'(w_en[i]), 32'(e_en[i]));
      chk("wr_dirty", 32'(w_d[i]), 32'(e_d[i]));
      chk("data_sel", 32'(w_s[i]), 32'(e_s[i]));
      if (e_s[i]) chk("fill_data", 32'(w_f[i]), 32'(rdata));
    end
    chk("mem_phases", 32'(m_we.size()), 32'(x_we.size()));
    for (int i = 0; i < x_we.size() && i < m_we.size(); i++) begin
      chk("mem_we", 32'(m_we[i]), 32'(x_we[i]));
      chk("mem_addr", 32'(m_a[i]), 32'(x_a[i]));
      chk("mem_wdata_en", 32'(m_en[i]), 32'(x_en[i]));
    end
    chk("hit_cnt", 32'(hit_cnt), 32'(m_hit));
    chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    chk("lat_addr", 32'(lat_addr), 32'(addr));
    chk("lat_wdata", 32'(lat_wdata), 32'(wdata));
  endtask
  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; hit = 0; dirty = 0; lru = 0;
    wb_addr = 0; mem_rdata = 0; mem_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(cpu_busy), 32'd0);
    chk("rst_done", 32'(cpu_done), 32'd0);
    chk("rst_wren", 32'(wren), 32'd0);
    chk("rst_hit_pulse", 32'(hit_pulse), 32'd0);
    chk("rst_flags", 32'({wr_dirty, data_sel, mem_req, mem_we, mem_wdata_en}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_fill_data", 32'(fill_data), 32'd0);
    chk("rst_lat", 32'({lat_addr, lat_wdata}), 32'd0);
    chk("rst_cnts", 32'({hit_cnt, miss_cnt}), 32'd0);
    rst = 1'b0;
    run_txn(1'b0, 8'h21, 8'h00, 4'b0100, 4'b0000, 4'b0001, 8'h00, 1, 1, 8'h00);
    run_txn(1'b1, 8'h42, 8'h5A, 4'b0010, 4'b0000, 4'b0001, 8'h00, 1, 1, 8'h00);
    run_txn(1'b0, 8'h63, 8'h00, 4'b0000, 4'b0000, 4'b1000, 8'h99, 1, 3, 8'hA5);
    run_txn(1'b1, 8'h84, 8'hC3, 4'b0000, 4'b0001, 4'b0001, 8'h3C, 2, 2, 8'h11);
    run_txn(1'b0, 8'h95, 8'h00, 4'b0000, 4'b0000, 4'b0110, 8'h00, 1, 1, 8'h22);
    run_txn(1'b0, 8'hA6, 8'h00, 4'b0000, 4'b1111, 4'b0000, 8'h55, 1, 2, 8'h33);
    run_txn(1'b1, 8'hB7, 8'h7E, 4'b0000, 4'b0010, 4'b1110, 8'h66, 3, 1, 8'h44);
    run_txn(1'b1, 8'hC8, 8'h81, 4'b0101, 4'b0000, 4'b0001, 8'h00, 1, 1, 8'h00);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h77; hit = 4'd0; dirty = 4'd0; lru = 4'b1000;
    k = 0;
    while (!mem_req && k < 10) begin @(negedge clk); k++; end
    chk("rst_reach_fill", 32'(mem_req), 32'd1);
    cpu_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; m_hit = 0; m_miss = 0;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_busy", 32'(cpu_busy), 32'd0);
    chk("midrst_done", 32'(cpu_done), 32'd0);
    mem_ack = 1'b1; bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (wren != 4'd0 || cpu_done || cpu_busy) bad = 1'b1;
    end
    chk("stray_ack", 32'(bad), 32'd0);
    run_txn(1'b0, 8'h0F, 8'h00, 4'b1000, 4'b0000, 4'b0001, 8'h00, 1, 1, 8'h00);
    for (int t = 0; t < 40; t++) begin
      h = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), h, 4'($urandom), 4'($urandom),
              8'($urandom), $urandom_range(1, 4), $urandom_range(1, 4), 8'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
